mips_region_checker: RTL and testbench
======================================

// Module: mips_region_checker
// PURPOSE
//  Synthesizable end-of-program result checker for the single-cycle MIPS core.
//  Watches the core PC. When it reaches END_PC: halts the core, scans COUNT words
//  of data memory from BASE_ADDR, checks sort order and compares each word with an
//  expected-value ROM. Latches pass/fail, error counts and a cycle-budget timeout.
//  Sits beside cpu; reads dmem through its debug read port.
// PARAMETERS
//  DATA_W        32        data word width
//  ADDR_W        10        dmem / expected-ROM word-address width
//  BASE_ADDR     32        first dmem word address of the checked region
//  COUNT         96        number of words checked (>=1)
//  END_PC        32'h78    PC value that triggers the check
//  DESCENDING    1         1: require prev>=cur; 0: require prev<=cur
//  SIGNED        0         1: order compare is two's-complement; 0: unsigned
//  CYCLE_BUDGET  25840     max cycles from reset release to trigger
// PORTS
//  clk           in   1        clock, rising edge
//  reset         in   1        asynchronous, active-low reset
//  pc            in   32       core program counter
//  mem_addr      out  ADDR_W   dmem debug read address (combinational read)
//  mem_rdata     in   DATA_W   dmem debug read data, valid same cycle
//  exp_addr      out  ADDR_W   expected-ROM address (combinational read)
//  exp_rdata     in   DATA_W   expected value
//  halt          out  1        freezes core (PC/regfile/dmem writes) while high
//  done          out  1        check complete, sticky
//  pass_sorted   out  1        valid when done: err_unsorted==0
//  pass_match    out  1        valid when done: err_exp==0
//  err_unsorted  out  ERR_W    order-violation count, ERR_W=$clog2(COUNT+1)
//  err_exp       out  ERR_W    expected-mismatch count
//  cycles        out  32       cycles from reset release to trigger, saturating
//  timeout       out  1        cycles > CYCLE_BUDGET, latched at trigger
// BEHAVIOUR
//  Reset (reset=0, async): state RUN; all outputs 0; idx=0; prev=0.
//  FSM RUN -> SCAN -> DONE; DONE holds until reset.
//   RUN:  cycles++ each edge, saturating at 2^32-1. If pc==END_PC at an edge:
//         go to SCAN, idx=0, halt=1 from next cycle, timeout<=(cycles>CYCLE_BUDGET).
//   SCAN: mem_addr=BASE_ADDR+idx, exp_addr=idx (truncated to ADDR_W).
//         Each edge: if mem_rdata!=exp_rdata, err_exp++.
//         If idx>0 and order(prev,mem_rdata) is violated, err_unsorted++.
//         prev<=mem_rdata; idx++. After idx==COUNT-1 is processed -> DONE.
//   DONE: halt=1, done=1, pass_* = (count==0). mem_addr/exp_addr = 0.
//  Timing: exactly COUNT cycles in SCAN; done rises on edge trigger+COUNT+1.
//  Only COUNT-1 adjacent pairs are ordered; nothing past the region is read.
//  Equal neighbours are legal in either mode. COUNT=1: no pair check, pass_sorted=1.
//  pc==END_PC in SCAN/DONE is ignored; a later pc change does not restart the check.
//  Counters cannot overflow (max COUNT). mem_addr/exp_addr = 0 in RUN.
//  Reset mid-SCAN: immediate async clear to RUN; a partial result is never flagged done.
// TESTING
//  1 96 distinct words descending, ROM identical, trigger cycle 2000 -> done at
//    trigger+97, pass_sorted=1, pass_match=1, errs 0, timeout=0.
//  2 As 1 but idx 10/11 swapped in dmem only -> err_unsorted=1, err_exp=2,
//    both pass_* = 0.
//  3 All 96 words 32'h5, ROM all 5 -> pass_sorted=1, pass_match=1.
//  4 SIGNED=1, DESCENDING=1, region {1, FFFFFFFF} with COUNT=2 -> err_unsorted=0;
//    SIGNED=0, same data -> err_unsorted=1.
//  5 Trigger at cycle CYCLE_BUDGET+1 -> timeout=1; at CYCLE_BUDGET -> timeout=0.
//  6 reset=0 at idx=40 during SCAN -> all outputs 0 same cycle; release and
//    retrigger -> case 1 result.

Source files
------------

// File: rtl/mips_region_checker_if.sv
// Debug read ports from the region checker into data memory and the expected-value ROM.
// Both reads are combinational: data is returned in the same cycle as the address.
interface mips_region_checker_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_rdata;

    modport master (
        output mem_addr,
        output exp_addr,
        input  mem_rdata,
        input  exp_rdata
    );

    modport slave (
        input  mem_addr,
        input  exp_addr,
        output mem_rdata,
        output exp_rdata
    );
endinterface

// File: rtl/mips_region_checker.sv
// End-of-program checker for the single-cycle MIPS core: on PC==END_PC it halts the core,
// scans a dmem region for sort order and against an expected ROM, and latches the verdict.
module mips_region_checker #(
    parameter int          DATA_W       = 32,
    parameter int          ADDR_W       = 10,
    parameter int unsigned BASE_ADDR    = 32,
    parameter int unsigned COUNT        = 96,
    parameter logic [31:0] END_PC       = 32'h78,
    parameter bit          DESCENDING   = 1'b1,
    parameter bit          SIGNED       = 1'b0,
    parameter int unsigned CYCLE_BUDGET = 25840,
    localparam int         ERR_W        = $clog2(COUNT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           pc,
    mips_region_checker_if.master rd,
    output logic                  halt,
    output logic                  done,
    output logic                  pass_sorted,
    output logic                  pass_match,
    output logic [ERR_W-1:0]      err_unsorted,
    output logic [ERR_W-1:0]      err_exp,
    output logic [31:0]           cycles,
    output logic                  timeout
);

    localparam int                IDX_W    = ERR_W;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(COUNT - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       BUDGET   = 32'(CYCLE_BUDGET);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  prev;
    logic [DATA_W-1:0]  cur;
    logic               prev_lt_cur;
    logic               cur_lt_prev;
    logic               order_bad;
    logic               exp_bad;

    assign cur = rd.mem_rdata;

    always_comb begin
        prev_lt_cur = 1'b0;
        cur_lt_prev = 1'b0;
        if (SIGNED) begin
            prev_lt_cur = $signed(prev) < $signed(cur);
            cur_lt_prev = $signed(cur) < $signed(prev);
        end else begin
            prev_lt_cur = prev < cur;
            cur_lt_prev = cur < prev;
        end
        // The first word has no predecessor, so only COUNT-1 pairs are ever judged.
        order_bad = (idx != '0) && (DESCENDING ? prev_lt_cur : cur_lt_prev);
        exp_bad   = (cur != rd.exp_rdata);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        halt        = 1'b0;
        rd.mem_addr = '0;
        rd.exp_addr = '0;
        case (state)
            ST_RUN: begin
                if (pc == END_PC) begin
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                halt        = 1'b1;
                rd.mem_addr = BASE + ADDR_W'(idx);
                rd.exp_addr = ADDR_W'(idx);
                if (idx == LAST_IDX) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                halt = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // cycles freezes on the trigger edge, so the reported count is exactly the value judged for timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles       <= '0;
            timeout      <= 1'b0;
            idx          <= '0;
            prev         <= '0;
            err_unsorted <= '0;
            err_exp      <= '0;
            done         <= 1'b0;
            pass_sorted  <= 1'b0;
            pass_match   <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (pc == END_PC) begin
                        idx     <= '0;
                        timeout <= (cycles > BUDGET);
                    end else if (cycles != '1) begin
                        cycles <= cycles + 32'd1;
                    end
                end
                ST_SCAN: begin
                    if (exp_bad) begin
                        err_exp <= err_exp + ERR_W'(1);
                    end
                    if (order_bad) begin
                        err_unsorted <= err_unsorted + ERR_W'(1);
                    end
                    prev <= cur;
                    idx  <= idx + IDX_W'(1);
                end
                ST_DONE: begin
                    done        <= 1'b1;
                    pass_sorted <= (err_unsorted == '0);
                    pass_match  <= (err_exp == '0);
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_region_checker.sv
// Scoreboard bench for mips_region_checker: one 96-word instance plus three 2-word instances
// covering signed/unsigned ordering and the cycle-budget boundary.
module tb_mips_region_checker;

    localparam logic [31:0] END_PC = 32'h78;

    typedef struct {
        int          id;
        int          tc;
        int unsigned done_edge;
        logic        ps;
        logic        pm;
        logic        to;
        logic [7:0]  eu;
        logic [7:0]  ee;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_a [4];

    logic        done_a [4];
    logic        halt_a [4];
    logic        ps_a   [4];
    logic        pm_a   [4];
    logic        to_a   [4];
    logic [7:0]  eu_a   [4];
    logic [7:0]  ee_a   [4];
    logic [31:0] cyc_a  [4];
    logic        done_prev [4];

    int unsigned edge_n   = 0;
    int unsigned rel_edge = 0;
    int          n_tests  = 0;
    int          n_fail   = 0;
    exp_t        sb [$];

    logic [31:0] dmem [0:1023];
    logic [31:0] rom  [0:1023];
    logic [31:0] smem [0:15];
    logic [31:0] srom [0:15];

    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;

    mips_region_checker_if #(.ADDR_W(10), .DATA_W(32)) m_if ();
    assign m_if.mem_rdata = dmem[m_if.mem_addr];
    assign m_if.exp_rdata = rom[m_if.exp_addr];

    logic        m_halt, m_done, m_ps, m_pm, m_to;
    logic [6:0]  m_eu, m_ee;
    logic [31:0] m_cyc;

    mips_region_checker #(
        .DATA_W(32), .ADDR_W(10), .BASE_ADDR(32), .COUNT(96), .END_PC(END_PC),
        .DESCENDING(1'b1), .SIGNED(1'b0), .CYCLE_BUDGET(25840)
    ) dut (
        .clk(clk), .reset(reset), .pc(pc_a[0]), .rd(m_if),
        .halt(m_halt), .done(m_done), .pass_sorted(m_ps), .pass_match(m_pm),
        .err_unsorted(m_eu), .err_exp(m_ee), .cycles(m_cyc), .timeout(m_to)
    );

    assign done_a[0] = m_done;
    assign halt_a[0] = m_halt;
    assign ps_a[0]   = m_ps;
    assign pm_a[0]   = m_pm;
    assign to_a[0]   = m_to;
    assign eu_a[0]   = {1'b0, m_eu};
    assign ee_a[0]   = {1'b0, m_ee};
    assign cyc_a[0]  = m_cyc;

    // Instance 1: signed descending, 2: unsigned descending, 3: signed with a 50-cycle budget.
    for (genvar g = 1; g < 4; g++) begin : g_small
        mips_region_checker_if #(.ADDR_W(4), .DATA_W(32)) s_if ();
        assign s_if.mem_rdata = smem[s_if.mem_addr];
        assign s_if.exp_rdata = srom[s_if.exp_addr];

        logic        h, d, ps, pm, to;
        logic [1:0]  eu, ee;
        logic [31:0] cyc;

        mips_region_checker #(
            .DATA_W(32), .ADDR_W(4), .BASE_ADDR(0), .COUNT(2), .END_PC(END_PC),
            .DESCENDING(1'b1), .SIGNED((g == 2) ? 1'b0 : 1'b1),
            .CYCLE_BUDGET((g == 3) ? 50 : 25840)
        ) dut (
            .clk(clk), .reset(reset), .pc(pc_a[g]), .rd(s_if),
            .halt(h), .done(d), .pass_sorted(ps), .pass_match(pm),
            .err_unsorted(eu), .err_exp(ee), .cycles(cyc), .timeout(to)
        );

        assign done_a[g] = d;
        assign halt_a[g] = h;
        assign ps_a[g]   = ps;
        assign pm_a[g]   = pm;
        assign to_a[g]   = to;
        assign eu_a[g]   = {6'd0, eu};
        assign ee_a[g]   = {6'd0, ee};
        assign cyc_a[g]  = cyc;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endfunction

    function automatic int unsigned count_of(input int id);
        return (id == 0) ? 96 : 2;
    endfunction

    function automatic exp_t mk(input int id, input int tc, input logic ps, input logic pm,
                                input logic to, input logic [7:0] eu, input logic [7:0] ee);
        exp_t x;
        x.id = id; x.tc = tc; x.ps = ps; x.pm = pm; x.to = to;
        x.eu = eu; x.ee = ee; x.done_edge = 0; x.cyc = 0;
        return x;
    endfunction

    function automatic logic [31:0] val(input int i);
        return 32'h0001_0000 - 32'(i * 7);
    endfunction

    // Monitor: on each rising done, pop the matching expectation; stale entries count as failures.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done_a[i] === 1'b1 && !done_prev[i]) begin
                int k;
                k = -1;
                for (int j = 0; j < sb.size(); j++) begin
                    if (k < 0 && sb[j].id == i) k = j;
                end
                if (k < 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_done: dut %0d got done=1, expected done=0", i);
                end else begin
                    exp_t e;
                    e = sb[k];
                    sb.delete(k);
                    check($sformatf("tc%0d_dut%0d_done_edge", e.tc, i), edge_n, e.done_edge);
                    check($sformatf("tc%0d_dut%0d_pass_sorted", e.tc, i), 32'(ps_a[i]), 32'(e.ps));
                    check($sformatf("tc%0d_dut%0d_pass_match", e.tc, i), 32'(pm_a[i]), 32'(e.pm));
                    check($sformatf("tc%0d_dut%0d_err_unsorted", e.tc, i), 32'(eu_a[i]), 32'(e.eu));
                    check($sformatf("tc%0d_dut%0d_err_exp", e.tc, i), 32'(ee_a[i]), 32'(e.ee));
                    check($sformatf("tc%0d_dut%0d_timeout", e.tc, i), 32'(to_a[i]), 32'(e.to));
                    check($sformatf("tc%0d_dut%0d_cycles", e.tc, i), cyc_a[i], e.cyc);
                    check($sformatf("tc%0d_dut%0d_halt", e.tc, i), 32'(halt_a[i]), 32'd1);
                end
            end
            done_prev[i] = (done_a[i] === 1'b1);
        end
        for (int j = 0; j < sb.size(); j++) begin
            if (edge_n > sb[j].done_edge + 3) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL tc%0d_dut%0d_no_done: got done=0 at edge %0d, expected done=1 at edge %0d",
                         sb[j].tc, sb[j].id, edge_n, sb[j].done_edge);
                sb.delete(j);
                break;
            end
        end
    end

    task automatic load_main(input int mode);
        for (int i = 0; i < 1024; i++) begin
            dmem[i] = 32'hDEAD_0000 + 32'(i);
            rom[i]  = 32'h0;
        end
        for (int i = 0; i < 96; i++) begin
            dmem[32 + i] = (mode == 2) ? 32'h5 : val(i);
            rom[i]       = (mode == 2) ? 32'h5 : val(i);
        end
        if (mode == 1) begin
            dmem[42] = val(11);
            dmem[43] = val(10);
        end
        dmem[128] = 32'hFFFF_FFFF;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_done"}, 32'(m_done), 32'd0);
        check({tag, "_halt"}, 32'(m_halt), 32'd0);
        check({tag, "_cycles"}, m_cyc, 32'd0);
        check({tag, "_err_unsorted"}, 32'(m_eu), 32'd0);
        check({tag, "_err_exp"}, 32'(m_ee), 32'd0);
        check({tag, "_pass_sorted"}, 32'(m_ps), 32'd0);
        check({tag, "_pass_match"}, 32'(m_pm), 32'd0);
        check({tag, "_timeout"}, 32'(m_to), 32'd0);
        check({tag, "_mem_addr"}, 32'(m_if.mem_addr), 32'd0);
        check({tag, "_exp_addr"}, 32'(m_if.exp_addr), 32'd0);
    endtask

    task automatic apply_stimulus_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) pc_a[i] = 32'd0;
        repeat (2) @(negedge clk);
        check_reset_state(tag);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("%s_dut%0d_cycles", tag, i), cyc_a[i], 32'd0);
        end
        reset    = 1'b1;
        rel_edge = edge_n;
    endtask

    // Drives pc to END_PC so that the trigger edge sees cycles == t, then queues the result.
    task automatic trigger_at(input exp_t x, input int unsigned t, input bit push);
        int unsigned guard;
        exp_t        y;
        guard = 0;
        while (edge_n < rel_edge + t && guard < 60000) begin
            @(negedge clk);
            guard++;
        end
        pc_a[x.id] = END_PC;
        @(posedge clk);
        #1;
        y           = x;
        y.done_edge = edge_n + count_of(x.id) + 1;
        y.cyc       = t;
        pc_a[x.id]  = 32'd0;
        if (push) sb.push_back(y);
    endtask

    task automatic wait_drain();
        int unsigned g;
        g = 0;
        while (sb.size() != 0 && g < 400) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc_a[i]      = 32'd0;
            done_prev[i] = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            smem[i] = 32'h0;
            srom[i] = 32'h0;
        end
        smem[0] = 32'h0000_0001;
        smem[1] = 32'hFFFF_FFFF;
        srom[0] = 32'h0000_0001;
        srom[1] = 32'hFFFF_FFFF;

        // Sorted region, plus signed/unsigned ordering and a budget overrun on the small instances.
        load_main(0);
        apply_stimulus_reset("rst1");
        fork
            trigger_at(mk(0, 1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0), 2000, 1'b1);
            trigger_at(mk(1, 4, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0), 10, 1'b1);
            trigger_at(mk(2, 4, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0), 10, 1'b1);
            trigger_at(mk(3, 5, 1'b1, 1'b1, 1'b1, 8'd0, 8'd0), 51, 1'b1);
        join
        check("tc1_scan_halt", 32'(m_halt), 32'd1);
        check("tc1_scan_mem_addr0", 32'(m_if.mem_addr), 32'd32);
        check("tc1_scan_exp_addr0", 32'(m_if.exp_addr), 32'd0);
        wait_drain();
        check("tc1_done_mem_addr", 32'(m_if.mem_addr), 32'd0);
        check("tc1_done_exp_addr", 32'(m_if.exp_addr), 32'd0);

        // Neighbours 10/11 swapped in dmem only; budget hit exactly on the small instance.
        load_main(1);
        apply_stimulus_reset("rst2");
        fork
            trigger_at(mk(0, 2, 1'b0, 1'b0, 1'b0, 8'd1, 8'd2), 300, 1'b1);
            trigger_at(mk(3, 5, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0), 50, 1'b1);
        join
        wait_drain();

        // All-equal region is sorted in descending mode.
        load_main(2);
        apply_stimulus_reset("rst3");
        trigger_at(mk(0, 3, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0), 150, 1'b1);
        wait_drain();

        // Reset in the middle of the scan, then a clean rerun.
        load_main(0);
        apply_stimulus_reset("rst4");
        trigger_at(mk(0, 6, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0), 100, 1'b0);
        repeat (41) @(negedge clk);
        check("tc6_idx40_mem_addr", 32'(m_if.mem_addr), 32'd72);
        check("tc6_idx40_exp_addr", 32'(m_if.exp_addr), 32'd40);
        check("tc6_idx40_halt", 32'(m_halt), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_state("tc6_midscan");
        repeat (2) @(negedge clk);
        reset    = 1'b1;
        rel_edge = edge_n;
        trigger_at(mk(0, 6, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0), 2000, 1'b1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
